pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Parametrised program-counter stage for the fetch front end. It holds the PC register and computes the sequential address (PC + STEP) and the PC-relative branch target with a chain of 4-bit carry-lookahead blocks. It selects the next PC from the sequential, branch and register-jump sources, and implements stall and a halt/drain state machine. It sits between the decode/branch-resolution logic and instruction-memory fetch.

## Interface
Parameters:
- WIDTH, 16, PC width in bits; must be a multiple of 4 and at least 8.
- STEP, 2, sequential increment in bytes.
- OFF_W, 9, width of the signed branch word offset.
- RESET_VEC, 0, PC value loaded on reset.
- DRAIN, 4, cycles between halt acceptance and `halted` assertion; range 1 to 15.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous, active-low reset.
- stall, input, 1, freeze the PC for this cycle.
- branch_taken, input, 1, redirect to the PC-relative target.
- br_offset, input, OFF_W, signed word offset; the byte offset is this value shifted left by 1.
- jump_reg, input, 1, redirect to `reg_target`.
- reg_target, input, WIDTH, absolute jump address.
- halt_req, input, 1, the decoded instruction is HLT.
- pc_out, output, WIDTH, current PC (registered).
- pc_plus, output, WIDTH, `pc_out` + STEP (combinational).
- br_target, output, WIDTH, `pc_plus` + (sign-extended `br_offset` << 1) (combinational).
- redirect, output, 1, registered; high for one cycle after a taken branch or jump is applied.
- halted, output, 1, registered; the processor is halted.

## Operation
- Adders:
  - Generated chain of WIDTH/4 CLA blocks, with the group carry rippled between blocks.
  - Carry-in is 0; carry-out is discarded.
  - All arithmetic is modulo 2^WIDTH, so the PC wraps silently.
  - `br_offset` is sign-extended to WIDTH before the shift.
- Next-PC priority, evaluated each cycle in RUN:
  1. stall: hold the PC.
  2. jump_reg: load `reg_target`.
  3. branch_taken: load `br_target`.
  4. halt_req: hold the PC, enter DRAIN.
  5. Otherwise: load `pc_plus`.
- If `jump_reg` and `branch_taken` are both high, the jump wins.
- A redirect in the same cycle as `halt_req` takes the redirect and ignores the halt.
- `halt_req` under stall is not accepted.
- FSM states:
  - RUN: normal operation.
  - DRAIN: PC frozen. A 4-bit counter loads DRAIN−1 on entry and decrements each cycle. When the counter is 0, go to HALTED.
  - HALTED: PC frozen; `halted` = 1.
  - While in DRAIN or HALTED, all inputs are ignored. Only reset leaves these states.
- `redirect` = 1 in the cycle after a jump or branch load, else 0.
- Reset, when `rst_n` = 0 at a clock edge, takes priority over everything in any state, including mid-DRAIN:
  - `pc_out` = RESET_VEC
  - FSM = RUN
  - counter = 0
  - `redirect` = 0
  - `halted` = 0

## Timing
- `pc_out` updates on the rising edge following the selecting inputs; the next-PC latency is 1 cycle.
- `pc_plus` and `br_target` are combinational from `pc_out` and `br_offset`, with no extra latency.
- Halt accepted at edge N:
  - `pc_out` is unchanged from edge N onward.
  - `halted` rises at edge N+DRAIN.
  - With DRAIN=1, `halted` rises one edge after acceptance.
- `redirect` is aligned with the first `pc_out` showing the new target.
- Stall is honoured in the same edge; it has no lookahead.

## Test plan
- Reset then run: hold `rst_n`=0 for 2 cycles, release, all controls 0 → `pc_out` = 0x0000, 0x0002, 0x0004, 0x0006 on successive cycles; `halted`=0 and `redirect`=0 throughout.
- Branch both directions:
  - At `pc_out`=0x0010, `branch_taken`=1, `br_offset`=+5 → next `pc_out`=0x001C with `redirect`=1 for one cycle.
  - At 0x0010, `br_offset`=−3 (0x1FD) → next `pc_out`=0x000C.
- Priority and stall:
  - At 0x0020, `jump_reg`=1 with `reg_target`=0x1234 and `branch_taken`=1 → 0x1234.
  - `stall`=1 together with `jump_reg`=1 → PC holds at 0x0020 and `redirect` stays 0.
- Wrap-around: with WIDTH=16 and PC at 0xFFFE, sequential step → 0x0000. Branch at 0xFFFC with `br_offset`=+2 → 0x0002.
- Halt and drain, with DRAIN=4:
  - `halt_req` at PC 0x0040 → PC stays 0x0040 and `halted` rises exactly 4 edges after acceptance.
  - Further `jump_reg` or `branch_taken` inputs are ignored.
  - `rst_n`=0 mid-DRAIN → PC=RESET_VEC, no halt, normal stepping resumes.
- Parametrised build: WIDTH=32, STEP=4, RESET_VEC=0x100 → after reset the PC sequence is 0x100, 0x104. A branch with `br_offset`=−1 from 0x104 → 0x106.

Source files
------------

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - fetch PC register with CLA next-PC adders, stall and halt/drain FSM
module pc_next_unit #(
  parameter int WIDTH     = 16,
  parameter int STEP      = 2,
  parameter int OFF_W     = 9,
  parameter int RESET_VEC = 0,
  parameter int DRAIN     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [OFF_W-1:0] br_offset,
  input  logic             jump_reg,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             halt_req,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] br_target,
  output logic             redirect,
  output logic             halted
);

  localparam int NB = WIDTH / 4;
  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VEC);
  localparam logic [3:0]       DRAIN_V = 4'(DRAIN - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             redirect_q, redirect_d;
  logic             halted_q, halted_d;

  logic [WIDTH-1:0] off_ext, off_sh;
  logic [NB-1:0]    cs, cb;

  function automatic logic [3:0] cla4_sum(input logic [3:0] a, input logic [3:0] b,
                                          input logic ci);
    logic [2:0] g;
    logic [3:0] p, c;
    g = a[2:0] & b[2:0];
    p = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return p ^ c;
  endfunction

  function automatic logic cla4_co(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] g, p;
    g = a & b;
    p = a ^ b;
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & ci);
  endfunction

  assign off_ext = WIDTH'($signed(br_offset));
  assign off_sh  = off_ext << 1;
  assign cs[0]   = 1'b0;
  assign cb[0]   = 1'b0;

  // Two CLA chains share the block structure: pc+STEP and pc_plus+offset.
  for (genvar gi = 0; gi < NB; gi++) begin : g_cla
    assign pc_plus[4*gi +: 4]   = cla4_sum(pc_q[4*gi +: 4], STEP_V[4*gi +: 4], cs[gi]);
    assign br_target[4*gi +: 4] = cla4_sum(pc_plus[4*gi +: 4], off_sh[4*gi +: 4], cb[gi]);
    if (gi < NB - 1) begin : g_carry
      assign cs[gi+1] = cla4_co(pc_q[4*gi +: 4], STEP_V[4*gi +: 4], cs[gi]);
      assign cb[gi+1] = cla4_co(pc_plus[4*gi +: 4], off_sh[4*gi +: 4], cb[gi]);
    end
  end

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    redirect_d = 1'b0;
    case (state_q)
      S_RUN: begin
        if (!stall) begin
          if (jump_reg) begin
            pc_d       = reg_target;
            redirect_d = 1'b1;
          end else if (branch_taken) begin
            pc_d       = br_target;
            redirect_d = 1'b1;
          end else if (halt_req) begin
            state_d = S_DRAIN;
            cnt_d   = DRAIN_V;
          end else begin
            pc_d = pc_plus;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == 4'd0) state_d = S_HALTED;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_HALTED;
    endcase
    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_V;
      state_q    <= S_RUN;
      cnt_q      <= 4'd0;
      redirect_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
      halted_q   <= halted_d;
    end
  end

  assign pc_out   = pc_q;
  assign redirect = redirect_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - directed bench for pc_next_unit, default and 32-bit builds
module tb_pc_next_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, branch_taken, jump_reg, halt_req;
  logic [8:0]  br_offset;
  logic [15:0] reg_target, pc_out, pc_plus, br_target;
  logic        redirect, halted;

  logic        b_rst_n, b_stall, b_branch, b_jump, b_halt_req;
  logic [8:0]  b_offset;
  logic [31:0] b_reg_target, b_pc_out, b_pc_plus, b_br_target;
  logic        b_redirect, b_halted;

  int tests = 0;
  int fails = 0;

  pc_next_unit u16 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .br_offset(br_offset), .jump_reg(jump_reg), .reg_target(reg_target),
    .halt_req(halt_req), .pc_out(pc_out), .pc_plus(pc_plus), .br_target(br_target),
    .redirect(redirect), .halted(halted)
  );

  pc_next_unit #(.WIDTH(32), .STEP(4), .OFF_W(9), .RESET_VEC(32'h100), .DRAIN(1)) u32 (
    .clk(clk), .rst_n(b_rst_n), .stall(b_stall), .branch_taken(b_branch),
    .br_offset(b_offset), .jump_reg(b_jump), .reg_target(b_reg_target),
    .halt_req(b_halt_req), .pc_out(b_pc_out), .pc_plus(b_pc_plus), .br_target(b_br_target),
    .redirect(b_redirect), .halted(b_halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] addr);
    jump_reg   = 1'b1;
    reg_target = addr;
    tick();
    jump_reg   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump_reg = 1'b0; halt_req = 1'b0;
    br_offset = 9'd0; reg_target = 16'd0;
    b_rst_n = 1'b0; b_stall = 1'b0; b_branch = 1'b0; b_jump = 1'b0; b_halt_req = 1'b0;
    b_offset = 9'd0; b_reg_target = 32'd0;

    tick(); tick();
    chk("reset_pc", pc_out, 16'h0000);
    chk("reset_redirect", redirect, 1'b0);
    chk("reset_halted", halted, 1'b0);
    chk("reset_pc_plus", pc_plus, 16'h0002);

    rst_n = 1'b1;
    tick(); chk("seq_2", pc_out, 16'h0002);
    tick(); chk("seq_4", pc_out, 16'h0004);
    tick(); chk("seq_6", pc_out, 16'h0006);
    chk("seq_redirect", redirect, 1'b0);
    chk("seq_halted", halted, 1'b0);

    go(16'h0010);
    chk("jump_pc", pc_out, 16'h0010);
    chk("jump_redirect", redirect, 1'b1);
    branch_taken = 1'b1; br_offset = 9'd5;
    #1 chk("br_fwd_target", br_target, 16'h001C);
    tick();
    chk("br_fwd_pc", pc_out, 16'h001C);
    chk("br_fwd_redirect", redirect, 1'b1);
    branch_taken = 1'b0;
    tick();
    chk("after_br_pc", pc_out, 16'h001E);
    chk("after_br_redirect", redirect, 1'b0);

    go(16'h0010);
    branch_taken = 1'b1; br_offset = 9'h1FD;
    tick();
    chk("br_back_pc", pc_out, 16'h000C);
    branch_taken = 1'b0;

    go(16'h0020);
    jump_reg = 1'b1; reg_target = 16'h1234; branch_taken = 1'b1; br_offset = 9'd5;
    tick();
    chk("prio_jump_pc", pc_out, 16'h1234);
    chk("prio_jump_redirect", redirect, 1'b1);
    branch_taken = 1'b0;
    jump_reg = 1'b0;

    go(16'h0020);
    stall = 1'b1; jump_reg = 1'b1; reg_target = 16'h1234;
    tick();
    chk("stall_pc", pc_out, 16'h0020);
    chk("stall_redirect", redirect, 1'b0);
    jump_reg = 1'b0; halt_req = 1'b1;
    tick();
    chk("stall_halt_pc", pc_out, 16'h0020);
    stall = 1'b0; halt_req = 1'b0;
    tick();
    chk("stall_halt_ignored", pc_out, 16'h0022);

    jump_reg = 1'b1; reg_target = 16'h0030; halt_req = 1'b1;
    tick();
    chk("redir_over_halt_pc", pc_out, 16'h0030);
    jump_reg = 1'b0; halt_req = 1'b0;
    tick();
    chk("redir_over_halt_step", pc_out, 16'h0032);

    go(16'hFFFE);
    tick();
    chk("wrap_seq", pc_out, 16'h0000);
    go(16'hFFFC);
    branch_taken = 1'b1; br_offset = 9'd2;
    tick();
    chk("wrap_branch", pc_out, 16'h0002);
    branch_taken = 1'b0;

    go(16'h0040);
    halt_req = 1'b1;
    tick();
    chk("halt_n_pc", pc_out, 16'h0040);
    chk("halt_n_halted", halted, 1'b0);
    halt_req = 1'b0; jump_reg = 1'b1; reg_target = 16'h1234; branch_taken = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("drain_%0d_halted", i), halted, 1'b0);
      chk($sformatf("drain_%0d_pc", i), pc_out, 16'h0040);
    end
    chk("drain_redirect", redirect, 1'b0);
    tick();
    chk("halt_n4_halted", halted, 1'b1);
    chk("halt_n4_pc", pc_out, 16'h0040);
    tick();
    chk("halted_sticky", halted, 1'b1);
    jump_reg = 1'b0; branch_taken = 1'b0;

    rst_n = 1'b0;
    tick();
    chk("rst_from_halt_pc", pc_out, 16'h0000);
    chk("rst_from_halt_halted", halted, 1'b0);
    rst_n = 1'b1;
    go(16'h0040);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("mid_drain_rst_pc", pc_out, 16'h0000);
    chk("mid_drain_rst_halted", halted, 1'b0);
    chk("mid_drain_rst_redirect", redirect, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_step", pc_out, 16'h0002);
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_run_pc", pc_out, 16'h000A);
    chk("post_rst_run_halted", halted, 1'b0);

    chk("w32_reset_pc", b_pc_out, 32'h0000_0100);
    b_rst_n = 1'b1;
    tick();
    chk("w32_seq", b_pc_out, 32'h0000_0104);
    b_branch = 1'b1; b_offset = 9'h1FF;
    #1 chk("w32_br_target", b_br_target, 32'h0000_0106);
    tick();
    chk("w32_br_pc", b_pc_out, 32'h0000_0106);
    chk("w32_br_redirect", b_redirect, 1'b1);
    b_branch = 1'b0; b_halt_req = 1'b1;
    tick();
    chk("w32_halt_n", b_halted, 1'b0);
    b_halt_req = 1'b0;
    tick();
    chk("w32_halt_n1", b_halted, 1'b1);
    chk("w32_halt_pc", b_pc_out, 32'h0000_0106);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
